adc_capture_buffer: RTL

// - Multi-channel triggered capture buffer for the ADC readout path; successor to the single-port-pair sample RAM.
// - Free-runs a circular write into one RAM per channel while armed, freezes on trigger after a programmable post-trigger count.
// - Presents the frozen record trigger-aligned: read_addr 0 is the oldest pre-trigger sample.
// - Sits between the ADC sampler and the host/readout interface.

---
 rtl/adc_capture_buffer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/adc_capture_buffer.sv
// Multi-channel triggered capture buffer: circular write while armed, freeze after the post-trigger count,
// trigger-aligned readout. Defining ADC_CAPTURE_LEVEL_TRIG_EN adds a channel-0 rising-level trigger.
module adc_capture_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CH     = 2,
  parameter int CH_WIDTH   = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         sample_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic                         trigger,
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
  input  logic [DATA_WIDTH-1:0]        trig_level,
`endif
  input  logic [ADDR_WIDTH-1:0]        pre_samples,
  input  logic [CH_WIDTH-1:0]          read_ch,
  input  logic [ADDR_WIDTH-1:0]        read_addr,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        trig_addr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic [ADDR_WIDTH-1:0] pre_lat;
  logic [ADDR_WIDTH:0]   post_cnt;
  logic [ADDR_WIDTH:0]   post_target;
  logic [ADDR_WIDTH-1:0] rd_phys;
  logic                  capturing;
  logic                  wr_en;
  logic                  trig_eff;

  logic [DATA_WIDTH-1:0] mem [NUM_CH][DEPTH];
  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_split
    assign ch_data[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
  // prev starts at all-ones so the first sample after reset can never look like a crossing
  logic [DATA_WIDTH-1:0] prev_ch0;
  logic                  crossing;

  assign crossing = (prev_ch0 < trig_level) && (trig_level <= ch_data[0]);
  assign trig_eff = trigger | crossing;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      prev_ch0 <= '1;
    else if (sample_valid)
      prev_ch0 <= ch_data[0];
  end
`else
  assign trig_eff = trigger;
`endif

  assign capturing   = (state == FILL) || (state == ARMED) || (state == POST);
  assign wr_en       = sample_valid && capturing && !abort;
  assign post_target = (ADDR_WIDTH+1)'(DEPTH) - {1'b0, pre_lat};
  assign rd_phys     = trig_addr - pre_lat + read_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wptr      <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      pre_lat   <= '0;
      trig_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (wr_en)
        wptr <= wptr + 1'b1;
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            pre_lat  <= pre_samples;
            fill_cnt <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= (pre_samples == '0) ? ARMED : FILL;
          end
        end
        FILL: begin
          if (sample_valid) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt + 1'b1 == pre_lat)
              state <= ARMED;
          end
        end
        ARMED: begin
          if (sample_valid && trig_eff) begin
            trig_addr <= wptr;
            post_cnt  <= {{ADDR_WIDTH{1'b0}}, 1'b1};
            if (pre_lat == '1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          if (sample_valid) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt + 1'b1 == post_target) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // all channels share one write address; the RAM itself is never reset
  always_ff @(posedge clock) begin
    if (wr_en)
      for (int k = 0; k < NUM_CH; k++)
        mem[k][wptr] <= ch_data[k];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      data_out <= '0;
    else if (32'(read_ch) < NUM_CH)
      data_out <= mem[read_ch][rd_phys];
    else
      data_out <= '0;
  end

endmodule
